rb_apb_master: RTL
==================

# rb_apb_master

APB initiator that converts a single-outstanding command/response handshake into AMBA APB (APB3) transfers. It is the requester-side counterpart to the register-block APB responder. Local masters such as the debug/loader path use it to reach UART and peripheral register blocks over APB. It runs one transfer at a time through SETUP and ACCESS phases, honours `apb_pready` wait states, and returns read data plus error status on a response channel.

## Interface
Parameters:
- `ADDR_W`, 12, APB address width
- `DATA_W`, 32, APB data width
- `TIMEOUT_CYCLES`, 255, ACCESS wait-state limit; used only when the timeout feature is compiled in (range 1..65535)

Ports:
- `apb_pclk`  in  1  clock; all logic on the rising edge
- `apb_preset`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  target address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when high together with `rsp_valid`
- `rsp_rdata`  out  DATA_W  read data; 0 for writes, errors and timeouts
- `rsp_err`  out  1  `apb_pslverr` was sampled high, or the transfer timed out
- `rsp_timeout`  out  1  transfer aborted by the watchdog
- `apb_paddr`  out  ADDR_W  APB address
- `apb_psel`  out  1  APB select
- `apb_penable`  out  1  APB enable
- `apb_pwrite`  out  1  APB direction
- `apb_pwdata`  out  DATA_W  APB write data
- `apb_pready`  in  1  responder ready
- `apb_prdata`  in  DATA_W  responder read data
- `apb_pslverr`  in  1  responder error

## Operation
- State machine: IDLE, SETUP, ACCESS, RESP.
- **IDLE**
  - `cmd_ready` = 1; all APB outputs are 0.
  - On `cmd_valid & cmd_ready`: latch write, address and wdata, then go to SETUP.
- **SETUP**
  - `apb_psel` = 1, `apb_penable` = 0.
  - `apb_paddr` / `apb_pwrite` / `apb_pwdata` are driven from the latched values.
  - `apb_pwdata` = 0 for reads.
  - Always advances to ACCESS after one cycle.
- **ACCESS**
  - `apb_psel` = 1, `apb_penable` = 1; address, direction and data are held stable.
  - If `apb_pready` = 1: capture `apb_prdata` (reads only, and only when `apb_pslverr` = 0, else 0) and `apb_pslverr` into response registers, then go to RESP.
  - If `apb_pready` = 0: stay in ACCESS.
- **RESP**
  - APB outputs return to 0; `rsp_valid` = 1.
  - Response fields are held until `rsp_ready`, then go to IDLE.
- `cmd_ready` is low in SETUP, ACCESS and RESP, so only one transfer is ever outstanding.
- `apb_pready`, `apb_prdata` and `apb_pslverr` are ignored outside ACCESS.
- All outputs are registered.

## Timing
- Reset values: `cmd_ready` = 1 and state = IDLE. Every other output is 0: `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout`, `apb_psel`, `apb_penable`, `apb_pwrite`, `apb_paddr`, `apb_pwdata`.
- Command accepted at edge N:
  - SETUP during cycle N+1.
  - ACCESS from cycle N+2.
  - With `apb_pready` = 1 at the first ACCESS cycle, `rsp_valid` rises at cycle N+3.
  - Each wait state adds one cycle.
- Back-to-back: response consumed at edge M gives IDLE at M+1; the next command can be accepted at M+1. Minimum is 4 cycles per transfer with zero wait states.
- Reset mid-operation (any state): on the next edge, return to IDLE, drop `apb_psel` / `apb_penable`, clear `rsp_valid`, and discard the pending command and response.
- `rsp_ready` held high while idle has no effect.

## Configuration
- Macro: `RB_APB_MASTER_TIMEOUT_EN`.
- **Defined**
  - A 16-bit counter clears on entry to ACCESS and increments every ACCESS cycle with `apb_pready` = 0.
  - When the counter equals `TIMEOUT_CYCLES` and `apb_pready` is still 0, abort to RESP with `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0. `apb_psel` / `apb_penable` drop on the next cycle.
  - If `apb_pready` = 1 arrives in the same cycle as the limit, the transfer completes normally.
- **Undefined**
  - No counter; ACCESS waits indefinitely.
  - `rsp_timeout` is tied to 0.

## Test plan
- **Zero-wait write:** write to 0x010 with data 0xA5A5_0001, `apb_pready` = 1 in ACCESS -> one SETUP cycle and one ACCESS cycle with `apb_paddr` = 0x010 and `apb_pwdata` = 0xA5A5_0001; `rsp_valid` 3 cycles after acceptance with `rsp_err` = 0 and `rsp_rdata` = 0.
- **Read with wait states:** read 0x004, `apb_pready` low for 3 cycles then high with `apb_prdata` = 0x1234_5678 -> ACCESS lasts 4 cycles with stable address; `rsp_rdata` = 0x1234_5678; `rsp_valid` at acceptance + 6.
- **Slave error:** read 0xFFC with `apb_pslverr` = 1 and `apb_pready` = 1 -> `rsp_err` = 1, `rsp_rdata` = 0.
- **Response backpressure:** `rsp_ready` held low for 5 cycles -> `rsp_valid` and fields stable, `cmd_ready` = 0 and APB idle throughout; the next command is accepted on the cycle after `rsp_ready`.
- **Timeout:** with `RB_APB_MASTER_TIMEOUT_EN` defined, `TIMEOUT_CYCLES` = 8 and `apb_pready` stuck at 0 -> the abort fires at the 9th ACCESS cycle, giving `rsp_err` = 1 and `rsp_timeout` = 1. Without the macro, the block is still in ACCESS after 1000 cycles.
- **Reset mid-ACCESS:** assert `apb_preset` for one cycle during a wait state -> `apb_psel` = 0 and `cmd_ready` = 1 on the next cycle, with no response issued.

Source files
------------

// File: rtl/rb_apb_master_if.sv
// Command/response and APB3 signal bundle for rb_apb_master.
// master: the initiator's view; slave: the peer driving commands and the APB responder.
interface rb_apb_master_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic [ADDR_W-1:0] apb_paddr;
  logic              apb_psel;
  logic              apb_penable;
  logic              apb_pwrite;
  logic [DATA_W-1:0] apb_pwdata;
  logic              apb_pready;
  logic [DATA_W-1:0] apb_prdata;
  logic              apb_pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  apb_pready, apb_prdata, apb_pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output apb_pready, apb_prdata, apb_pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
  );
endinterface

// File: rtl/rb_apb_master.sv
// Single-outstanding command/response to APB3 initiator; all outputs registered.
// Optional ACCESS watchdog compiled in with RB_APB_MASTER_TIMEOUT_EN.
module rb_apb_master #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              apb_pclk,
  input  logic              apb_preset,
  rb_apb_master_if.master   bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
`ifdef RB_APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);
  logic [15:0]       cnt_q, cnt_d;
  logic              rsp_timeout_q, rsp_timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef RB_APB_MASTER_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        // cmd_ready_q is high exactly while idle, so cmd_valid alone is the handshake here
        if (bus.cmd_valid) begin
          state_d  = StSetup;
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
        end
      end
      StSetup: begin
        state_d = StAccess;
`ifdef RB_APB_MASTER_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      StAccess: begin
        if (bus.apb_pready) begin
          state_d     = StResp;
          rsp_rdata_d = (!pwrite_q && !bus.apb_pslverr) ? bus.apb_prdata : '0;
          rsp_err_d   = bus.apb_pslverr;
`ifdef RB_APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == TimeoutLimit) begin
          state_d       = StResp;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d     = StIdle;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
`ifdef RB_APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // APB address/direction/data are only non-zero while the bus is selected
    if (state_d == StIdle || state_d == StResp) begin
      pwrite_d = 1'b0;
      paddr_d  = '0;
      pwdata_d = '0;
    end

    cmd_ready_d = (state_d == StIdle);
    psel_d      = (state_d == StSetup) || (state_d == StAccess);
    penable_d   = (state_d == StAccess);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge apb_pclk) begin
    if (apb_preset) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef RB_APB_MASTER_TIMEOUT_EN
  always_ff @(posedge apb_pclk) begin
    if (apb_preset) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.rsp_timeout = rsp_timeout_q;
`else
  assign bus.rsp_timeout = 1'b0;
`endif

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.apb_psel    = psel_q;
  assign bus.apb_penable = penable_q;
  assign bus.apb_pwrite  = pwrite_q;
  assign bus.apb_paddr   = paddr_q;
  assign bus.apb_pwdata  = pwdata_q;

endmodule
